memory_stage_inner: RTL and testbench

// - MEM stage of the 5-stage RV32I pipeline: EX -> this block -> WB.
// - Loads and stores run as a Wishbone B4 classic master; all other instructions pass through one register stage.
// - Drives the bypass bus (forwarding_out) and relays stall/jump status from WB back to EX.

---
 rtl/pipeline_pkg.sv | 50 +++++
 rtl/memory_stage_inner_if.sv | 34 +++
 rtl/load_store_align.sv | 59 +++++
 rtl/memory_stage_inner.sv | 180 ++++++++++++++++++
 tb/tb_memory_stage_inner.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipeline_pkg
// Description : Types and constants shared by the RV32I pipeline stages:
//               stage status encodings, the decoded instruction layout,
//               the bypass bus layout and the opcodes the MEM stage decodes.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    // Forward status travelling with each instruction. Encodings outside
    // this set are treated as BUBBLE by consumers.
    typedef enum logic [3:0] {
        SF_BUBBLE    = 4'd0,
        SF_VALID     = 4'd1,
        SF_EXCEPTION = 4'd2
    } status_forwards_t;

    // Backward status from a later stage. Encoding 3 is treated as READY.
    typedef enum logic [1:0] {
        SB_READY = 2'd0,
        SB_STALL = 2'd1,
        SB_JUMP  = 2'd2
    } status_backwards_t;

    // Decoded instruction, 65 bits; first member is the MSB.
    typedef struct packed {
        logic        illegal;   // [64]
        logic [6:0]  funct7;    // [63:57]
        logic [2:0]  funct3;    // [56:54]
        logic [6:0]  opcode;    // [53:47]
        logic [4:0]  rd;        // [46:42]
        logic [4:0]  rs2;       // [41:37]
        logic [4:0]  rs1;       // [36:32]
        logic [31:0] imm;       // [31:0]
    } instruction_t;

    // Bypass bus, 38 bits.
    typedef struct packed {
        logic        valid;     // [37]
        logic [4:0]  rd;        // [36:32]
        logic [31:0] data;      // [31:0]
    } forwarding_t;

    localparam logic [6:0] c_opcode_load   = 7'b0000011;
    localparam logic [6:0] c_opcode_store  = 7'b0100011;
    localparam logic [6:0] c_opcode_branch = 7'b1100011;

endpackage
`default_nettype wire

// File: rtl/memory_stage_inner_if.sv
`default_nettype none
// ============================================================================
// Interface   : memory_stage_inner_if
// Description : Wishbone B4 classic bus between the MEM stage (master) and
//               the data memory (slave).
//               master: drives cyc, stb, we, sel, adr, dat_mosi
//                       samples dat_miso, ack, err
//               slave : the mirror image
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_stage_inner_if;

    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_mosi;
    logic [31:0] wb_dat_miso;
    logic        wb_ack;
    logic        wb_err;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_mosi,
        input  wb_dat_miso, wb_ack, wb_err
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_mosi,
        output wb_dat_miso, wb_ack, wb_err
    );

endinterface
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// ============================================================================
// Module      : load_store_align
// Description : Pure combinational lane steering for loads and stores.
//               i_funct3      access size / signedness (RV32I funct3)
//               i_addr_lo     effective address bits [1:0]
//               i_store_data  rs2 value
//               i_load_raw    word returned by the bus
//               o_sel         byte lane enables
//               o_store_data  store data moved onto its lanes
//               o_load_data   extracted and extended load result
//               o_misaligned  access crosses its natural alignment
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_align (
    input  wire logic [2:0]  i_funct3,
    input  wire logic [1:0]  i_addr_lo,
    input  wire logic [31:0] i_store_data,
    input  wire logic [31:0] i_load_raw,
    output logic      [3:0]  o_sel,
    output logic      [31:0] o_store_data,
    output logic      [31:0] o_load_data,
    output logic             o_misaligned
);

    logic [4:0]  w_shamt;
    logic [31:0] w_load_shifted;

    assign w_shamt        = {i_addr_lo, 3'b000};
    assign o_store_data   = i_store_data << w_shamt;
    assign w_load_shifted = i_load_raw >> w_shamt;

    // funct3[1:0]: 00 byte, 01 half, anything else handled as a word.
    always_comb begin
        o_sel        = 4'b1111;
        o_misaligned = 1'b0;
        case (i_funct3[1:0])
            2'b00: o_sel = 4'b0001 << i_addr_lo;
            2'b01: begin
                o_sel        = 4'b0011 << i_addr_lo;
                o_misaligned = i_addr_lo[0];
            end
            default: o_misaligned = (i_addr_lo != 2'b00);
        endcase
    end

    always_comb begin
        o_load_data = w_load_shifted;
        case (i_funct3)
            3'b000:  o_load_data = {{24{w_load_shifted[7]}},  w_load_shifted[7:0]};
            3'b001:  o_load_data = {{16{w_load_shifted[15]}}, w_load_shifted[15:0]};
            3'b100:  o_load_data = {24'd0, w_load_shifted[7:0]};
            3'b101:  o_load_data = {16'd0, w_load_shifted[15:0]};
            default: o_load_data = w_load_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/memory_stage_inner.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage_inner
// Description : MEM stage of the 5-stage RV32I pipeline (EX -> MEM -> WB).
//               Loads/stores run as a Wishbone B4 classic master; every
//               other instruction passes through one register stage.
//               clk, rst                      clock / sync active-high reset
//               status_forwards_in/out        stage status towards WB
//               status_backwards_in/out       READY/STALL/JUMP towards EX
//               *_in / *_reg_out              captured instruction context;
//                                             rd_data_reg_out carries loads
//               jump_address_backwards_in/out jump target relayed to EX
//               forwarding_out                bypass bus {valid, rd, data}
//               wb                            Wishbone master port
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage_inner
    import pipeline_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic [3:0]   status_forwards_in,
    output logic      [3:0]   status_forwards_out,
    input  wire logic [1:0]   status_backwards_in,
    output logic      [1:0]   status_backwards_out,
    input  wire logic [31:0]  source_data_in,
    input  wire logic [31:0]  rd_data_in,
    input  wire instruction_t instruction_in,
    input  wire logic [31:0]  program_counter_in,
    input  wire logic [31:0]  next_program_counter_in,
    output logic      [31:0]  source_data_reg_out,
    output logic      [31:0]  rd_data_reg_out,
    output instruction_t      instruction_reg_out,
    output logic      [31:0]  program_counter_reg_out,
    output logic      [31:0]  next_program_counter_reg_out,
    input  wire logic [31:0]  jump_address_backwards_in,
    output logic      [31:0]  jump_address_backwards_out,
    output forwarding_t       forwarding_out,
    memory_stage_inner_if.master wb
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUS  = 1'b1;

    logic [0:0]   r_state, w_state_next;
    logic [3:0]   r_status;
    logic [31:0]  r_src, r_rd_data, r_pc, r_npc;
    instruction_t r_instr;
    logic         r_we;
    logic [3:0]   r_sel;
    logic [31:0]  r_adr, r_dat_mosi;

    logic         w_jump, w_stall_in, w_accept, w_launch, w_bus_done;
    logic         w_is_mem, w_mem_valid, w_mem_fault;
    logic [3:0]   w_status_capture;
    logic [1:0]   w_align_addr;
    logic [2:0]   w_align_funct3;
    logic [3:0]   w_sel;
    logic [31:0]  w_store_data, w_load_data;
    logic         w_misaligned;

    assign w_jump     = (status_backwards_in == SB_JUMP);
    assign w_stall_in = (status_backwards_in == SB_STALL);
    assign w_accept   = (r_state == S_IDLE) && !w_stall_in && !w_jump;
    assign w_bus_done = wb.wb_ack | wb.wb_err;

    assign w_is_mem    = (instruction_in.opcode == c_opcode_load) ||
                         (instruction_in.opcode == c_opcode_store);
    assign w_mem_valid = w_is_mem && (status_forwards_in == SF_VALID);
    assign w_mem_fault = w_misaligned || instruction_in.illegal;
    assign w_launch    = w_accept && w_mem_valid && !w_mem_fault;

    // One aligner serves both phases: in IDLE it steers the incoming access,
    // in BUS it extracts the load from the captured address and funct3.
    assign w_align_addr   = (r_state == S_BUS) ? r_rd_data[1:0] : rd_data_in[1:0];
    assign w_align_funct3 = (r_state == S_BUS) ? r_instr.funct3 : instruction_in.funct3;

    load_store_align u_align (
        .i_funct3     (w_align_funct3),
        .i_addr_lo    (w_align_addr),
        .i_store_data (source_data_in),
        .i_load_raw   (wb.wb_dat_miso),
        .o_sel        (w_sel),
        .o_store_data (w_store_data),
        .o_load_data  (w_load_data),
        .o_misaligned (w_misaligned)
    );

    // Status captured on acceptance; unknown encodings collapse to BUBBLE
    // and an in-flight memory access reports BUBBLE until it terminates.
    always_comb begin
        w_status_capture = SF_BUBBLE;
        if (w_mem_valid)
            w_status_capture = w_mem_fault ? SF_EXCEPTION : SF_BUBBLE;
        else if (status_forwards_in == SF_VALID || status_forwards_in == SF_EXCEPTION)
            w_status_capture = status_forwards_in;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == S_IDLE) begin
            if (w_launch) w_state_next = S_BUS;
        end else begin
            if (w_jump || w_bus_done) w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status   <= '0;
            r_src      <= '0;
            r_rd_data  <= '0;
            r_instr    <= '0;
            r_pc       <= '0;
            r_npc      <= '0;
            r_we       <= 1'b0;
            r_sel      <= '0;
            r_adr      <= '0;
            r_dat_mosi <= '0;
        end else if (w_jump) begin
            r_status <= SF_BUBBLE;
        end else if (r_state == S_BUS) begin
            if (w_bus_done) begin
                r_status <= wb.wb_err ? SF_EXCEPTION : SF_VALID;
                if (!wb.wb_err && !r_we) r_rd_data <= w_load_data;
            end
        end else if (!w_stall_in) begin
            r_status   <= w_status_capture;
            r_src      <= source_data_in;
            r_rd_data  <= rd_data_in;
            r_instr    <= instruction_in;
            r_pc       <= program_counter_in;
            r_npc      <= next_program_counter_in;
            r_we       <= (instruction_in.opcode == c_opcode_store);
            r_sel      <= w_sel;
            r_adr      <= {rd_data_in[31:2], 2'b00};
            r_dat_mosi <= w_store_data;
        end
    end

    always_comb begin
        status_backwards_out = SB_READY;
        if (rst)
            status_backwards_out = SB_READY;
        else if (w_jump)
            status_backwards_out = SB_JUMP;
        else if (r_state == S_BUS || w_stall_in)
            status_backwards_out = SB_STALL;
    end

    assign jump_address_backwards_out = jump_address_backwards_in;

    // In BUS the status register holds BUBBLE, so a pending load never forwards.
    assign forwarding_out.valid = (r_status == SF_VALID) && (r_instr.rd != 5'd0) &&
                                  (r_instr.opcode != c_opcode_store) &&
                                  (r_instr.opcode != c_opcode_branch);
    assign forwarding_out.rd    = r_instr.rd;
    assign forwarding_out.data  = r_rd_data;

    assign status_forwards_out          = r_status;
    assign source_data_reg_out          = r_src;
    assign rd_data_reg_out              = r_rd_data;
    assign instruction_reg_out          = r_instr;
    assign program_counter_reg_out      = r_pc;
    assign next_program_counter_reg_out = r_npc;

    assign wb.wb_cyc      = (r_state == S_BUS);
    assign wb.wb_stb      = (r_state == S_BUS);
    assign wb.wb_we       = (r_state == S_BUS) && r_we;
    assign wb.wb_sel      = r_sel;
    assign wb.wb_adr      = r_adr;
    assign wb.wb_dat_mosi = r_dat_mosi;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage_inner.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_stage_inner
// Description : Self-checking bench for memory_stage_inner: directed cases
//               followed by randomized instructions compared against a
//               transaction-level model of the MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_memory_stage_inner;
    import pipeline_pkg::*;

    localparam logic [6:0] c_op_alu  = 7'b0110011;
    localparam logic [6:0] c_op_alui = 7'b0010011;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   sf_in, sf_out;
    logic [1:0]   sb_in, sb_out;
    logic [31:0]  src_in, rd_in, pc_in, npc_in, ja_in, ja_out;
    logic [31:0]  src_reg, rd_reg, pc_reg, npc_reg;
    instruction_t instr_in, instr_reg;
    forwarding_t  fwd;

    int n_cmp = 0;
    int n_bad = 0;

    memory_stage_inner_if wb_bus();

    always #5 clk = ~clk;

    memory_stage_inner dut (
        .clk                          (clk),
        .rst                          (rst),
        .status_forwards_in           (sf_in),
        .status_forwards_out          (sf_out),
        .status_backwards_in          (sb_in),
        .status_backwards_out         (sb_out),
        .source_data_in               (src_in),
        .rd_data_in                   (rd_in),
        .instruction_in               (instr_in),
        .program_counter_in           (pc_in),
        .next_program_counter_in      (npc_in),
        .source_data_reg_out          (src_reg),
        .rd_data_reg_out              (rd_reg),
        .instruction_reg_out          (instr_reg),
        .program_counter_reg_out      (pc_reg),
        .next_program_counter_reg_out (npc_reg),
        .jump_address_backwards_in    (ja_in),
        .jump_address_backwards_out   (ja_out),
        .forwarding_out               (fwd),
        .wb                           (wb_bus)
    );

    task automatic chk_value(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic instruction_t mk_instr(input logic [6:0] op, input logic [2:0] f3,
                                              input logic [4:0] rd, input logic ill);
        instruction_t t;
        t.imm     = $urandom;
        t.rs1     = 5'($urandom);
        t.rs2     = 5'($urandom);
        t.funct7  = 7'($urandom);
        t.rd      = rd;
        t.opcode  = op;
        t.funct3  = f3;
        t.illegal = ill;
        return t;
    endfunction

    // Load result from the spec rules using plain integer arithmetic.
    function automatic logic [31:0] load_model(input logic [31:0] miso, input int a,
                                               input logic [2:0] f3);
        longint u, v;
        u = miso;
        u = u / (longint'(1) << (8 * a));
        case (f3)
            3'd0: begin v = u % 256;   if (v >= 128)   v = v - 256;   end
            3'd1: begin v = u % 65536; if (v >= 32768) v = v - 65536; end
            3'd4: v = u % 256;
            3'd5: v = u % 65536;
            default: v = u;
        endcase
        return v[31:0];
    endfunction

    // One instruction through the stage, with an optional bus transaction.
    task automatic run_instr(input logic [3:0] st, input logic [6:0] op, input logic [2:0] f3,
                             input logic [4:0] rd, input logic ill, input logic [31:0] addr,
                             input logic [31:0] src, input int waits, input logic use_err,
                             input logic [31:0] miso);
        instruction_t ins;
        logic [31:0]  pc, exp_rd, exp_mosi, ja;
        logic [3:0]   exp_status, exp_sel;
        logic         is_mem, is_store, fault, exp_fv, check_data;
        int           a, sz;

        ins = mk_instr(op, f3, rd, ill);
        pc  = $urandom;
        ja  = $urandom;
        sf_in = st; sb_in = SB_READY; rd_in = addr; src_in = src;
        instr_in = ins; pc_in = pc; npc_in = pc + 32'd4; ja_in = ja;
        #1;
        chk_value("ready_before_accept", 72'(sb_out), 72'(SB_READY));
        chk_value("jump_addr_relay", 72'(ja_out), 72'(ja));

        @(posedge clk); #1;
        sf_in = SF_BUBBLE; rd_in = $urandom; src_in = $urandom;
        instr_in = mk_instr(7'($urandom), 3'($urandom), 5'($urandom), 1'b0);
        pc_in = $urandom;
        #1;

        a        = int'(addr[1:0]);
        sz       = int'(f3[1:0]);
        is_mem   = (st == 4'd1) && (op == c_opcode_load || op == c_opcode_store);
        is_store = (op == c_opcode_store);
        fault    = ill || (sz == 1 && (a % 2) != 0) || (sz >= 2 && a != 0);
        exp_rd   = addr;
        check_data = 1'b1;

        if (is_mem && !fault) begin
            if (sz == 0)      exp_sel = 4'(1 << a);
            else if (sz == 1) exp_sel = 4'(3 << a);
            else              exp_sel = 4'd15;
            exp_mosi = src << (8 * a);
            chk_value("bus_cyc", 72'(wb_bus.wb_cyc), 72'(1));
            chk_value("bus_stb", 72'(wb_bus.wb_stb), 72'(1));
            chk_value("bus_we", 72'(wb_bus.wb_we), 72'(is_store));
            chk_value("bus_sel", 72'(wb_bus.wb_sel), 72'(exp_sel));
            chk_value("bus_adr", 72'(wb_bus.wb_adr), 72'(addr & 32'hFFFF_FFFC));
            if (is_store) chk_value("bus_mosi", 72'(wb_bus.wb_dat_mosi), 72'(exp_mosi));
            chk_value("stall_in_bus", 72'(sb_out), 72'(SB_STALL));
            chk_value("bubble_in_bus", 72'(sf_out), 72'(SF_BUBBLE));
            chk_value("no_fwd_in_bus", 72'(fwd.valid), 72'(0));
            for (int k = 0; k < waits; k++) begin
                @(posedge clk); #1;
                chk_value("bus_wait_cyc", 72'(wb_bus.wb_cyc), 72'(1));
            end
            wb_bus.wb_ack = !use_err; wb_bus.wb_err = use_err; wb_bus.wb_dat_miso = miso;
            @(posedge clk); #1;
            wb_bus.wb_ack = 1'b0; wb_bus.wb_err = 1'b0; wb_bus.wb_dat_miso = $urandom;
            #1;
            chk_value("bus_end_cyc", 72'(wb_bus.wb_cyc), 72'(0));
            chk_value("ready_after_bus", 72'(sb_out), 72'(SB_READY));
            exp_status = use_err ? SF_EXCEPTION : SF_VALID;
            if (!is_store && !use_err) exp_rd = load_model(miso, a, f3);
            if (!is_store && use_err)  check_data = 1'b0;
        end else begin
            chk_value("no_bus_cyc", 72'(wb_bus.wb_cyc), 72'(0));
            if (is_mem)                                 exp_status = SF_EXCEPTION;
            else if (st == 4'd1 || st == 4'd2)          exp_status = st;
            else                                        exp_status = SF_BUBBLE;
        end

        exp_fv = (exp_status == SF_VALID) && (rd != 5'd0) &&
                 (op != c_opcode_store) && (op != c_opcode_branch);
        chk_value("status_out", 72'(sf_out), 72'(exp_status));
        chk_value("fwd_valid", 72'(fwd.valid), 72'(exp_fv));
        chk_value("fwd_rd", 72'(fwd.rd), 72'(rd));
        if (check_data) begin
            chk_value("rd_data_reg", 72'(rd_reg), 72'(exp_rd));
            chk_value("fwd_data", 72'(fwd.data), 72'(exp_rd));
        end
        chk_value("instr_reg", 72'(instr_reg), 72'(ins));
        chk_value("pc_reg", 72'(pc_reg), 72'(pc));
        chk_value("npc_reg", 72'(npc_reg), 72'(pc + 32'd4));
        chk_value("src_reg", 72'(src_reg), 72'(src));
    endtask

    initial begin
        logic [6:0]   op;
        logic [3:0]   st;
        logic [2:0]   f3;
        logic [31:0]  addr;
        instruction_t hold_instr;

        rst = 1'b1; sf_in = SF_VALID; sb_in = SB_STALL;
        src_in = 32'h1; rd_in = 32'h2; pc_in = 32'h3; npc_in = 32'h4; ja_in = 32'h0;
        instr_in = mk_instr(c_op_alu, 3'd0, 5'd1, 1'b0);
        wb_bus.wb_ack = 1'b0; wb_bus.wb_err = 1'b0; wb_bus.wb_dat_miso = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_value("rst_status", 72'(sf_out), 72'(SF_BUBBLE));
        chk_value("rst_backwards_ready", 72'(sb_out), 72'(SB_READY));
        chk_value("rst_cyc", 72'(wb_bus.wb_cyc), 72'(0));
        chk_value("rst_rd_reg", 72'(rd_reg), 72'(0));
        chk_value("rst_fwd", 72'(fwd), 72'(0));
        rst = 1'b0; sb_in = SB_READY; sf_in = SF_BUBBLE;
        @(posedge clk); #1;

        // ADD, LB with waits, SH, misaligned LW, LW terminated by err
        run_instr(SF_VALID, c_op_alu, 3'd0, 5'd5, 1'b0, 32'h0000_1234, 32'h9, 0, 1'b0, 32'h0);
        run_instr(SF_VALID, c_opcode_load, 3'd0, 5'd3, 1'b0, 32'h0000_0103, 32'h0, 2, 1'b0, 32'h80FF_FFFF);
        run_instr(SF_VALID, c_opcode_store, 3'd1, 5'd0, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 1, 1'b0, 32'h0);
        run_instr(SF_VALID, c_opcode_load, 3'd2, 5'd4, 1'b0, 32'h0000_0301, 32'h0, 0, 1'b0, 32'h0);
        run_instr(SF_VALID, c_opcode_load, 3'd2, 5'd6, 1'b0, 32'h0000_0400, 32'h0, 1, 1'b1, 32'h1234_5678);

        // ack with no active cycle is ignored
        wb_bus.wb_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_value("stray_ack_cyc", 72'(wb_bus.wb_cyc), 72'(0));
        chk_value("stray_ack_status", 72'(sf_out), 72'(SF_BUBBLE));
        wb_bus.wb_ack = 1'b0;

        // JUMP during BUS abandons the cycle and blocks acceptance that cycle
        sf_in = SF_VALID; rd_in = 32'h40; instr_in = mk_instr(c_opcode_load, 3'd2, 5'd8, 1'b0);
        @(posedge clk); #1;
        chk_value("jump_pre_cyc", 72'(wb_bus.wb_cyc), 72'(1));
        sb_in = SB_JUMP; ja_in = 32'h80; rd_in = 32'h55;
        instr_in = mk_instr(c_op_alu, 3'd0, 5'd7, 1'b0);
        #1;
        chk_value("jump_addr_out", 72'(ja_out), 72'(32'h80));
        chk_value("jump_backwards", 72'(sb_out), 72'(SB_JUMP));
        @(posedge clk); #1;
        chk_value("jump_cyc_low", 72'(wb_bus.wb_cyc), 72'(0));
        chk_value("jump_bubble", 72'(sf_out), 72'(SF_BUBBLE));
        chk_value("jump_no_accept", 72'(rd_reg), 72'(32'h40));
        sb_in = SB_READY;
        @(posedge clk); #1;
        chk_value("post_jump_accept", 72'(sf_out), 72'(SF_VALID));
        chk_value("post_jump_rd", 72'(rd_reg), 72'(32'h55));
        sf_in = SF_BUBBLE;

        // downstream STALL while VALID holds every output register
        sf_in = SF_VALID; rd_in = 32'hCAFE; src_in = 32'h1111; pc_in = 32'h200; npc_in = 32'h204;
        hold_instr = mk_instr(c_op_alui, 3'd0, 5'd9, 1'b0);
        instr_in = hold_instr;
        @(posedge clk); #1;
        chk_value("hold_pre_status", 72'(sf_out), 72'(SF_VALID));
        sb_in = SB_STALL; rd_in = 32'hDEAD; src_in = 32'h2222; pc_in = 32'h300; npc_in = 32'h304;
        instr_in = mk_instr(c_op_alu, 3'd1, 5'd2, 1'b0);
        #1;
        chk_value("hold_backwards", 72'(sb_out), 72'(SB_STALL));
        repeat (2) @(posedge clk);
        #1;
        chk_value("hold_status", 72'(sf_out), 72'(SF_VALID));
        chk_value("hold_rd", 72'(rd_reg), 72'(32'hCAFE));
        chk_value("hold_src", 72'(src_reg), 72'(32'h1111));
        chk_value("hold_pc", 72'(pc_reg), 72'(32'h200));
        chk_value("hold_npc", 72'(npc_reg), 72'(32'h204));
        chk_value("hold_instr", 72'(instr_reg), 72'(hold_instr));
        chk_value("hold_fwd", 72'(fwd), 72'({1'b1, 5'd9, 32'hCAFE}));
        sb_in = SB_READY; sf_in = SF_BUBBLE;
        @(posedge clk); #1;

        // reset together with ack mid-BUS: reset wins
        sf_in = SF_VALID; rd_in = 32'h10; instr_in = mk_instr(c_opcode_load, 3'd4, 5'd3, 1'b0);
        @(posedge clk); #1;
        sf_in = SF_BUBBLE;
        chk_value("rst_bus_pre_cyc", 72'(wb_bus.wb_cyc), 72'(1));
        rst = 1'b1; wb_bus.wb_ack = 1'b1; wb_bus.wb_dat_miso = 32'hFFFF_FFFF;
        #1;
        chk_value("rst_bus_ready", 72'(sb_out), 72'(SB_READY));
        @(posedge clk); #1;
        rst = 1'b0; wb_bus.wb_ack = 1'b0;
        chk_value("rst_bus_cyc", 72'(wb_bus.wb_cyc), 72'(0));
        chk_value("rst_bus_status", 72'(sf_out), 72'(SF_BUBBLE));
        chk_value("rst_bus_rd", 72'(rd_reg), 72'(0));

        // randomized instruction stream
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 6))
                0, 1:    op = c_opcode_load;
                2, 3:    op = c_opcode_store;
                4:       op = c_op_alu;
                5:       op = c_opcode_branch;
                default: op = c_op_alui;
            endcase
            case ($urandom_range(0, 5))
                0:       st = SF_BUBBLE;
                1:       st = SF_EXCEPTION;
                2:       st = 4'(8 + $urandom_range(0, 7));
                default: st = SF_VALID;
            endcase
            if (op == c_opcode_load) begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'd0;
                    1:       f3 = 3'd1;
                    2:       f3 = 3'd2;
                    3:       f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end else if (op == c_opcode_store) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                f3 = 3'($urandom);
            end
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr = addr & 32'hFFFF_FFFC;
            run_instr(st, op, f3, 5'($urandom), ($urandom_range(0, 7) == 0), addr, $urandom,
                      $urandom_range(0, 3), ($urandom_range(0, 5) == 0), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
